// File: rtl/line_fill_pkg.sv
// Shared types and sizes for the line fill buffer.
// Holds the fill FSM state enum, the sizes derived from the default
// geometry, and packed beat/line types.
package line_fill_pkg;

    localparam int WORD_W_D         = 16;
    localparam int WORDS_PER_LINE_D = 8;
    localparam int BEAT_WORDS_D     = 4;
    localparam int WAY_W_D          = 2;
    localparam int INDEX_W_D        = 3;

    localparam int BEATS  = WORDS_PER_LINE_D / BEAT_WORDS_D;
    localparam int LINE_W = WORDS_PER_LINE_D * WORD_W_D;
    localparam int BEAT_W = BEAT_WORDS_D * WORD_W_D;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } fill_state_t;

    // Offset/counter width helper: at least one bit even for a single entry.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_fill_buffer_beat_word_sel.sv
// beat_word_sel: combinational pick of one word out of a memory beat.
// Ports:
//   beat  - BEAT_WORDS*WORD_W beat, word 0 in LSBs
//   off   - word offset within the beat
//   word  - selected word
module beat_word_sel
    import line_fill_pkg::*;
#(
    parameter int WORD_W     = WORD_W_D,
    parameter int BEAT_WORDS = BEAT_WORDS_D,
    parameter int OFF_W      = min1_clog2(BEAT_WORDS)
) (
    input  logic [BEAT_WORDS*WORD_W-1:0] beat,
    input  logic [OFF_W-1:0]             off,
    output logic [WORD_W-1:0]            word
);

    assign word = beat[off*WORD_W +: WORD_W];

endmodule

// File: rtl/line_fill_buffer.sv
// line_fill_buffer: gathers memory read beats into one cache line and
// hands the line to the data array (way/set chosen at request time).
// Optional critical-word-first forwarding is built when
// LINE_FILL_BUFFER_CWF_EN is defined; otherwise fwd_* are tied to 0.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            fill request handshake (ready only in IDLE)
//   req_way/req_index/req_word     destination way/set and critical word
//   mem_read                       held high while beats are being collected
//   mem_resp/mem_rdata             one beat per cycle with mem_resp high
//   fwd_valid/fwd_data             critical word pulse (CWF build only)
//   wr_valid/wr_ready              line write handshake to the data array
//   wr_way/wr_index/wr_line        write destination and assembled line
//   busy                           not idle
module line_fill_buffer
    import line_fill_pkg::*;
#(
    parameter int WORD_W         = WORD_W_D,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_D,
    parameter int BEAT_WORDS     = BEAT_WORDS_D,
    parameter int WAY_W          = WAY_W_D,
    parameter int INDEX_W        = INDEX_W_D
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [WAY_W-1:0]                 req_way,
    input  logic [INDEX_W-1:0]               req_index,
    input  logic [2:0]                       req_word,
    output logic                             mem_read,
    input  logic                             mem_resp,
    input  logic [BEAT_WORDS*WORD_W-1:0]     mem_rdata,
    output logic                             fwd_valid,
    output logic [WORD_W-1:0]                fwd_data,
    output logic                             wr_valid,
    input  logic                             wr_ready,
    output logic [WAY_W-1:0]                 wr_way,
    output logic [INDEX_W-1:0]               wr_index,
    output logic [WORDS_PER_LINE*WORD_W-1:0] wr_line,
    output logic                             busy
);

    localparam int NBEATS = WORDS_PER_LINE / BEAT_WORDS;
    localparam int BW     = BEAT_WORDS * WORD_W;
    localparam int LW     = WORDS_PER_LINE * WORD_W;
    localparam int CW     = min1_clog2(NBEATS);
    localparam int OFF_W  = min1_clog2(BEAT_WORDS);

    fill_state_t         state;
    logic [CW-1:0]       cnt;
    logic [LW-1:0]       line;
    logic [WAY_W-1:0]    way_r;
    logic [INDEX_W-1:0]  index_r;
    logic [2:0]          word_r;
    logic                req_ready_r, mem_read_r, wr_valid_r;

    wire last_beat = (cnt == CW'(NBEATS - 1));

    // Control outputs are registered alongside the state so that they
    // change on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            line        <= '0;
            way_r       <= '0;
            index_r     <= '0;
            word_r      <= '0;
            req_ready_r <= 1'b1;
            mem_read_r  <= 1'b0;
            wr_valid_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        way_r       <= req_way;
                        index_r     <= req_index;
                        word_r      <= req_word;
                        cnt         <= '0;
                        state       <= FILL;
                        req_ready_r <= 1'b0;
                        mem_read_r  <= 1'b1;
                    end
                end
                FILL: begin
                    if (mem_resp) begin
                        line[cnt*BW +: BW] <= mem_rdata;
                        if (last_beat) begin
                            cnt        <= '0;
                            state      <= WRITE;
                            mem_read_r <= 1'b0;
                            wr_valid_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        state       <= IDLE;
                        wr_valid_r  <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_r <= 1'b1;
                    mem_read_r  <= 1'b0;
                    wr_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = !req_ready_r;
    assign mem_read  = mem_read_r;
    assign wr_valid  = wr_valid_r;
    assign wr_way    = way_r;
    assign wr_index  = index_r;
    assign wr_line   = line;

    // Critical word: beat number is req_word / BEAT_WORDS, offset inside
    // that beat is req_word % BEAT_WORDS.
    logic [OFF_W-1:0]  crit_off;
    logic [CW-1:0]     crit_beat;
    logic [WORD_W-1:0] crit_word;

    assign crit_off  = OFF_W'(32'(word_r) % BEAT_WORDS);
    assign crit_beat = CW'(32'(word_r) / BEAT_WORDS);

    beat_word_sel #(
        .WORD_W     (WORD_W),
        .BEAT_WORDS (BEAT_WORDS),
        .OFF_W      (OFF_W)
    ) u_sel (
        .beat (mem_rdata),
        .off  (crit_off),
        .word (crit_word)
    );

`ifdef LINE_FILL_BUFFER_CWF_EN
    logic              fwd_valid_r;
    logic [WORD_W-1:0] fwd_data_r;
    wire               fwd_hit = (state == FILL) && mem_resp && (cnt == crit_beat);

    // fwd_data keeps the last forwarded word; only fwd_valid is a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid_r <= 1'b0;
            fwd_data_r  <= '0;
        end else begin
            fwd_valid_r <= fwd_hit;
            if (fwd_hit) fwd_data_r <= crit_word;
        end
    end

    assign fwd_valid = fwd_valid_r;
    assign fwd_data  = fwd_data_r;
`else
    // Selector output has no load here and is trimmed in synthesis.
    logic unused_cwf;
    assign unused_cwf = ^{crit_word, crit_beat};
    assign fwd_valid  = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Assembles a full cache line from memory read beats and writes it into the selected way/set of the data array.
- Sits directly upstream of the 32:1 way/word read mux. The mux then selects the 16-bit word out of the refreshed lines.
- Optionally forwards the CPU's requested (critical) word as soon as its beat arrives, before the line write.

Parameters:
- WORD_W, 16, width of one CPU word.
- WORDS_PER_LINE, 8, words per cache line.
- BEAT_WORDS, 4, words per memory beat. BEATS = WORDS_PER_LINE/BEAT_WORDS (default 2).
- WAY_W, 2, way select width (4 ways).
- INDEX_W, 3, set index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  fill request.
- req_ready  out  1  high only in IDLE.
- req_way  in  WAY_W  destination way.
- req_index  in  INDEX_W  destination set.
- req_word  in  3  critical word offset within line.
- mem_read  out  1  memory read request, held through FILL.
- mem_resp  in  1  one beat valid this cycle.
- mem_rdata  in  BEAT_WORDS*WORD_W  beat data; word 0 in LSBs.
- fwd_valid  out  1  critical word valid pulse.
- fwd_data  out  WORD_W  critical word.
- wr_valid  out  1  line write request to data array.
- wr_ready  in  1  data array accepts write.
- wr_way  out  WAY_W  registered req_way.
- wr_index  out  INDEX_W  registered req_index.
- wr_line  out  WORDS_PER_LINE*WORD_W  assembled line; word 0 in LSBs.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; beat counter=0; line register=0.
  - All outputs 0 except req_ready=1.
  - Reset mid-FILL or mid-WRITE discards the partial line and drops mem_read/wr_valid immediately.
- States: IDLE, FILL, WRITE. All outputs are decoded from registered state/registers (no combinational paths from inputs to outputs).
- IDLE:
  - req_valid&&req_ready accepts the request: captures way/index/word, clears beat counter, goes to FILL.
  - mem_resp and wr_ready are ignored.
- FILL:
  - mem_read=1.
  - Each cycle with mem_resp=1, beat b (counter value) is written into line words [b*BEAT_WORDS +: BEAT_WORDS] and the counter increments.
  - Beats arrive in order 0..BEATS-1. The counter uses $clog2(BEATS) bits, minimum 1.
  - On the last beat, the counter wraps to 0 and the state goes to WRITE, so mem_read falls the next cycle.
  - mem_resp=0 cycles stall with no change.
- WRITE:
  - wr_valid=1; wr_line/wr_way/wr_index are stable while wr_valid=1.
  - wr_ready=1 goes to IDLE. wr_valid is held indefinitely until then.
  - mem_resp in WRITE is ignored; the line is not modified.
- New requests are never accepted outside IDLE. A req_valid in the same cycle as the wr handshake is accepted one cycle later, in IDLE.
- Latency: accept at cycle 0; mem_read=1 from cycle 1. With back-to-back beats at cycles 1..BEATS, wr_valid=1 at cycle BEATS+1.
- busy = !req_ready.

Optional Feature:
- LINE_FILL_BUFFER_CWF_EN defined:
  - The cycle after the beat containing req_word is captured, fwd_valid pulses high for exactly one cycle.
  - fwd_data = word (req_word % BEAT_WORDS) of that beat, registered. It holds its value until the next forward.
- Not defined: fwd_valid and fwd_data are tied 0; no forwarding logic is built.

Decomposition:
- Package line_fill_pkg holds:
  - fill_state_t enum {IDLE, FILL, WRITE};
  - localparams BEATS, LINE_W, BEAT_W, CNT_W derived from the defaults;
  - beat/line packed typedefs.
- One sub-module: beat_word_sel, a combinational selector of one WORD_W word from a beat by offset. It is used by the CWF path.

Test Plan:
- Basic fill: way=2, index=5, word=0; beats 0x0004_0003_0002_0001 then 0x0008_0007_0006_0005 on cycles 1,2, wr_ready=1 -> wr_valid at cycle 3 with wr_line=0x0008..0001 ascending, wr_way=2, wr_index=5, IDLE at cycle 4.
- Stalled beats: mem_resp gaps of 3 cycles between beats -> mem_read held high throughout, wr_line correct, no extra beat captured.
- Write backpressure: wr_ready low 5 cycles -> wr_valid and wr_line stable 5 cycles, req_ready=0, a new req_valid is not accepted until after the handshake.
- Reset mid-FILL: rst_n low after beat 0 -> mem_read=0 immediately, line=0; a new fill afterwards is not corrupted by old data.
- CWF (macro defined): req_word=6, beat1=0x0008_0007_0006_0005 -> fwd_valid one cycle after beat1 with fwd_data=0x0007. Macro undefined -> fwd_valid never asserts.
- Spurious mem_resp in IDLE/WRITE -> no state change, wr_line unchanged.
